// File: rtl/universal_shift_register.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with a shared shift counter that pulses frame_done once every WIDTH shifts.
module universal_shift_register #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shifting;

  // Both shift directions advance the same frame counter.
  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shifting = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: q_d = q_q;
        MODE_SHR: begin
          q_d      = {serial_in_r, q_q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], serial_in_l};
          shifting = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = par_in;
          cnt_d = '0;
        end
        default: q_d = q_q;
      endcase
      if (shifting) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign par_out      = q_q;
  assign serial_out_r = q_q[0];
  assign serial_out_l = q_q[WIDTH-1];
  assign shift_cnt    = cnt_q;
  assign frame_done   = done_q;

endmodule
